// File: rtl/uart_byte_emitter.sv
// uart_byte_emitter: FIFO-buffered 8N1 UART transmitter with a registered TX line.
module uart_byte_emitter #(
   parameter int clk_freq_hz     = 16000000,
   parameter int baud_rate       = 57600,
   parameter int fifo_depth_log2 = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [7:0]               i_data,
   input  logic                     i_valid,
   output logic                     o_ready,
   output logic                     o_uart_tx,
   output logic                     o_busy,
   output logic [fifo_depth_log2:0] o_level
);
   localparam int div   = clk_freq_hz / baud_rate;
   localparam int depth = 2 ** fifo_depth_log2;
   localparam int cw    = (div < 2) ? 1 : $clog2(div);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   generate
      if (div < 2) begin : g_div_check
         $error("uart_byte_emitter: clk_freq_hz / baud_rate must be at least 2");
      end
   endgenerate
   logic [7:0]                 mem [depth];
   logic [fifo_depth_log2-1:0] wr_ptr, rd_ptr;
   logic [fifo_depth_log2:0]   level_n;
   state_t                     state, state_n;
   logic [cw-1:0]              baud_cnt, baud_n;
   logic [2:0]                 bit_idx, bit_n;
   logic [7:0]                 shift, shift_n;
   logic                       accept, pop, baud_end, has_data, tx_n;
   assign o_ready  = (o_level != (fifo_depth_log2+1)'(depth)) & !i_rst;
   assign accept   = i_valid & o_ready;
   assign has_data = o_level != '0;
   assign baud_end = baud_cnt == cw'(div - 1);
   assign level_n  = o_level + (fifo_depth_log2+1)'(accept) - (fifo_depth_log2+1)'(pop);
   always_comb begin
      state_n = state;
      baud_n  = baud_cnt + 1'b1;
      bit_n   = bit_idx;
      shift_n = shift;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            baud_n = '0;
            if (has_data) begin
               pop     = 1'b1;
               shift_n = mem[rd_ptr];
               state_n = START;
            end
         end
         START: if (baud_end) begin
            baud_n  = '0;
            bit_n   = '0;
            state_n = DATA;
         end
         DATA: if (baud_end) begin
            baud_n  = '0;
            shift_n = shift >> 1;
            bit_n   = bit_idx + 1'b1;
            state_n = (bit_idx == 3'd7) ? STOP : DATA;
         end
         STOP: if (baud_end) begin
            // back-to-back frames: pop on the last stop cycle so no idle gap appears
            baud_n  = '0;
            pop     = has_data;
            shift_n = has_data ? mem[rd_ptr] : shift;
            state_n = has_data ? START : IDLE;
         end
         default: ;
      endcase
      tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : 1'b1;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         o_level   <= '0;
         o_uart_tx <= 1'b1;
         o_busy    <= 1'b0;
      end else begin
         state     <= state_n;
         baud_cnt  <= baud_n;
         bit_idx   <= bit_n;
         shift     <= shift_n;
         o_level   <= level_n;
         o_uart_tx <= tx_n;
         o_busy    <= (state_n != IDLE) | (level_n != '0);
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge i_clk) begin
      if (accept) mem[wr_ptr] <= i_data;
   end
endmodule

// File: tb/tb_uart_byte_emitter.sv
// tb_uart_byte_emitter: directed checks of the UART emitter at DIV = 10, FIFO depth 4.
module tb_uart_byte_emitter;
   logic       i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0;
   logic [7:0] i_data = '0;
   logic       o_ready, o_uart_tx, o_busy;
   logic [2:0] o_level;
   int         checks = 0, errors = 0;
   typedef struct { logic [7:0] data; logic [9:0] seq; } vec_t;
   vec_t       vecs [6];
   uart_byte_emitter #(.clk_freq_hz(1000), .baud_rate(100), .fifo_depth_log2(2)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
      .o_ready(o_ready), .o_uart_tx(o_uart_tx), .o_busy(o_busy), .o_level(o_level)
   );
   always #5 i_clk = ~i_clk;
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask
   // seq holds the line levels in transmit order, MSB first; each level lasts 10 cycles
   task automatic expect_frame(input string name, input logic [9:0] seq, input bit push, input logic [7:0] d);
      for (int k = 0; k < 100; k++) begin
         chk($sformatf("%s slot%0d", name, k / 10), 32'(o_uart_tx), 32'(seq[9 - k / 10]));
         if (push && k == 99) begin
            i_valid = 1'b1;
            i_data  = d;
         end
         step();
         i_valid = 1'b0;
      end
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end
   initial begin
      int cnt, bad;
      vecs[0] = '{8'hA5, 10'b0101001011};
      vecs[1] = '{8'h00, 10'b0000000001};
      vecs[2] = '{8'hFF, 10'b0111111111};
      vecs[3] = '{8'h3C, 10'b0001111001};
      vecs[4] = '{8'h01, 10'b0100000001};
      vecs[5] = '{8'h80, 10'b0000000011};
      repeat (3) step();
      chk("rst_tx", 32'(o_uart_tx), 1);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_level", 32'(o_level), 0);
      chk("rst_ready", 32'(o_ready), 0);
      i_valid = 1'b1;
      i_data  = 8'h77;
      step();
      i_rst   = 1'b0;
      i_valid = 1'b0;
      step();
      chk("rst_drop_level", 32'(o_level), 0);
      chk("rst_drop_tx", 32'(o_uart_tx), 1);
      chk("rst_drop_busy", 32'(o_busy), 0);
      chk("post_rst_ready", 32'(o_ready), 1);
      for (int i = 0; i < 6; i++) begin
         i_valid = 1'b1;
         i_data  = vecs[i].data;
         chk("single_ready", 32'(o_ready), 1);
         step();
         i_valid = 1'b0;
         chk("single_level", 32'(o_level), 1);
         chk("single_busy", 32'(o_busy), 1);
         chk("single_idle_tx", 32'(o_uart_tx), 1);
         step();
         expect_frame($sformatf("single_%0h", vecs[i].data), vecs[i].seq, 1'b0, 8'h00);
         chk("single_busy_end", 32'(o_busy), 0);
         chk("single_level_end", 32'(o_level), 0);
         chk("single_tx_end", 32'(o_uart_tx), 1);
      end
      i_valid = 1'b1;
      i_data  = 8'h00;
      step();
      i_data  = 8'hFF;
      step();
      i_valid = 1'b0;
      chk("b2b_level", 32'(o_level), 1);
      expect_frame("b2b_first", vecs[1].seq, 1'b0, 8'h00);
      expect_frame("b2b_second", vecs[2].seq, 1'b0, 8'h00);
      chk("b2b_busy_end", 32'(o_busy), 0);
      i_valid = 1'b1;
      i_data  = vecs[5].data;
      step();
      i_valid = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         i_valid = 1'b1;
         i_data  = vecs[i].data;
         chk("full_push_ready", 32'(o_ready), 1);
         step();
      end
      i_data = vecs[4].data;
      chk("full_ready_low", 32'(o_ready), 0);
      chk("full_level", 32'(o_level), 4);
      cnt = 0;
      while (!o_ready && cnt < 300) begin
         step();
         cnt++;
      end
      chk("full_ready_rise_cycles", 32'(cnt), 96);
      expect_frame("full_b0", vecs[0].seq, 1'b0, 8'h00);
      chk("full_level_after_b0", 32'(o_level), 3);
      for (int i = 1; i < 5; i++) expect_frame($sformatf("full_b%0d", i), vecs[i].seq, 1'b0, 8'h00);
      chk("full_busy_end", 32'(o_busy), 0);
      chk("full_level_end", 32'(o_level), 0);
      i_valid = 1'b1;
      i_data  = vecs[0].data;
      step();
      i_data  = vecs[3].data;
      step();
      i_valid = 1'b0;
      chk("simul_level_pre", 32'(o_level), 1);
      expect_frame("simul_x", vecs[0].seq, 1'b1, vecs[4].data);
      chk("simul_level", 32'(o_level), 1);
      expect_frame("simul_y", vecs[3].seq, 1'b0, 8'h00);
      expect_frame("simul_z", vecs[4].seq, 1'b0, 8'h00);
      chk("simul_busy_end", 32'(o_busy), 0);
      i_valid = 1'b1;
      i_data  = 8'h3C;
      step();
      i_data  = 8'h11;
      step();
      i_data  = 8'h22;
      step();
      i_valid = 1'b0;
      chk("midrst_level_pre", 32'(o_level), 2);
      repeat (43) step();
      chk("midrst_bit3", 32'(o_uart_tx), 1);
      chk("midrst_busy_pre", 32'(o_busy), 1);
      i_rst = 1'b1;
      #1;
      chk("midrst_ready", 32'(o_ready), 0);
      step();
      chk("midrst_tx", 32'(o_uart_tx), 1);
      chk("midrst_level", 32'(o_level), 0);
      chk("midrst_busy", 32'(o_busy), 0);
      i_rst = 1'b0;
      bad = 0;
      repeat (300) begin
         step();
         if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) bad++;
      end
      chk("midrst_no_frame", 32'(bad), 0);
      fork
         begin
            for (int n = 0; n < 256; n++) begin
               int w;
               w       = 0;
               i_valid = 1'b1;
               i_data  = 8'(n);
               while (!o_ready && w < 1000) begin
                  step();
                  w++;
               end
               chk("prod_wait", 32'(w < 1000), 1);
               step();
            end
            i_valid = 1'b0;
         end
         begin
            for (int n = 0; n < 256; n++) begin
               int         w;
               logic [7:0] b;
               logic       fe;
               w = 0;
               while (o_uart_tx !== 1'b0 && w < 2000) begin
                  step();
                  w++;
               end
               chk("dec_start_timeout", 32'(w < 2000), 1);
               if (w >= 2000) break;
               repeat (4) step();
               fe = o_uart_tx !== 1'b0;
               for (int j = 0; j < 8; j++) begin
                  repeat (10) step();
                  b[j] = o_uart_tx;
               end
               repeat (10) step();
               fe = fe | (o_uart_tx !== 1'b1);
               chk("dec_framing", 32'(fe), 0);
               chk("dec_byte", 32'(b), 32'(n));
            end
         end
      join
      repeat (20) step();
      chk("final_busy", 32'(o_busy), 0);
      chk("final_level", 32'(o_level), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
